// File: rtl/rca_pkg.sv
// Shared definitions for the multi-precision add sequencer:
// the datapath word width and the sequencer state encoding.
package rca_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rca_seq_state_t;

endpackage

// File: rtl/rca_mp_add_seq_if.sv
// Requester/consumer bus of the multi-precision add sequencer.
// The master side drives operands and accepts results; the slave side is the sequencer.
interface rca_mp_add_seq_if
    import rca_pkg::*;
#(
    parameter int WORDS = 4
);

    logic                      in_valid;
    logic                      in_ready;
    logic [WORD_W*WORDS-1:0]   a;
    logic [WORD_W*WORDS-1:0]   b;
    logic                      c_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W*WORDS-1:0]   s;
    logic                      c_out;
    logic                      busy;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, s, c_out, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, s, c_out, busy
    );

endinterface

// File: rtl/rca_mp_add_seq_rca16.sv
// Single-word ripple-carry adder shared by the sequencer.
// Purely combinational: one carry chain across WORD_W bits.
module rca_mp_add_seq_rca16
    import rca_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              carry_in,
    output logic [WORD_W-1:0] sum,
    output logic              carry_out
);

    logic [WORD_W:0] cy;

    always_comb begin
        cy    = '0;
        sum   = '0;
        cy[0] = carry_in;
        for (int i = 0; i < WORD_W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ cy[i];
            cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
    end

    assign carry_out = cy[WORD_W];

endmodule

// File: rtl/rca_mp_add_seq.sv
// Multi-precision add sequencer: adds WORDS x 16-bit operands one word per cycle,
// least significant word first, through a single shared ripple-carry adder.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid; s/c_out hold previous result
// RUN   | one word added per cycle, carry registered between words
// DONE  | out_valid high, result held until out_ready
module rca_mp_add_seq
    import rca_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    rca_mp_add_seq_if.slave    bus
);

    localparam int OP_W  = WORD_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    rca_seq_state_t    state;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic [OP_W-1:0]   s_reg;
    logic              carry;
    logic              c_out_reg;
    logic [IDX_W-1:0]  idx;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic [WORD_W-1:0] sum_word;
    logic              carry_next;
    logic              last_word;

    assign a_word    = a_reg[WORD_W*idx +: WORD_W];
    assign b_word    = b_reg[WORD_W*idx +: WORD_W];
    assign last_word = (idx == IDX_W'(WORDS - 1));

    rca_mp_add_seq_rca16 u_rca16 (
        .a         (a_word),
        .b         (b_word),
        .carry_in  (carry),
        .sum       (sum_word),
        .carry_out (carry_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            s_reg         <= '0;
            carry         <= 1'b0;
            c_out_reg     <= 1'b0;
            idx           <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        carry        <= bus.c_in;
                        idx          <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    s_reg[WORD_W*idx +: WORD_W] <= sum_word;
                    carry                       <= carry_next;
                    if (last_word) begin
                        c_out_reg     <= carry_next;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // No re-accept here: IDLE is always entered for at least one cycle.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.s         = s_reg;
    assign bus.c_out     = c_out_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_rca_mp_add_seq.sv
// Bench for rca_mp_add_seq: directed checks on a 4-word instance, then a random
// regression driving 2-, 4- and 7-word instances in parallel against a reference sum.
module tb_rca_mp_add_seq;

    localparam int MAXW = 7;
    localparam int MAXB = 16 * MAXW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rca_mp_add_seq_if #(.WORDS(2)) if2 ();
    rca_mp_add_seq_if #(.WORDS(4)) if4 ();
    rca_mp_add_seq_if #(.WORDS(7)) if7 ();

    rca_mp_add_seq #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    rca_mp_add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    rca_mp_add_seq #(.WORDS(7)) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [MAXB:0] sb [3][$];

    task automatic chk(input string tag, input logic [MAXB:0] obs, input logic [MAXB:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int words_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 4 : 7;
    endfunction

    // Reference: (16*w)-bit operands zero-extended, so the 16*w+1-bit result holds c_out.
    function automatic logic [MAXB:0] ref_sum(input logic [MAXB-1:0] a, input logic [MAXB-1:0] b,
                                              input logic cin, input int w);
        logic [MAXB:0] m;
        m = (({{MAXB{1'b0}}, 1'b1}) << (16 * w)) - 1'b1;
        return ({1'b0, a} & m) + ({1'b0, b} & m) + {{MAXB{1'b0}}, cin};
    endfunction

    function automatic logic [MAXB:0] obs_of(input int g);
        case (g)
            0:       return (MAXB+1)'({if2.c_out, if2.s});
            1:       return (MAXB+1)'({if4.c_out, if4.s});
            default: return (MAXB+1)'({if7.c_out, if7.s});
        endcase
    endfunction

    function automatic logic ovalid_of(input int g);
        case (g)
            0:       return if2.out_valid;
            1:       return if4.out_valid;
            default: return if7.out_valid;
        endcase
    endfunction

    task automatic set_ordy(input int g, input logic v);
        case (g)
            0:       if2.out_ready = v;
            1:       if4.out_ready = v;
            default: if7.out_ready = v;
        endcase
    endtask

    task automatic drive_all(input logic [MAXB-1:0] a, input logic [MAXB-1:0] b, input logic cin, input logic v);
        if2.a = a[31:0];  if2.b = b[31:0];  if2.c_in = cin; if2.in_valid = v;
        if4.a = a[63:0];  if4.b = b[63:0];  if4.c_in = cin; if4.in_valid = v;
        if7.a = a;        if7.b = b;        if7.c_in = cin; if7.in_valid = v;
    endtask

    // Directed op on the 4-word instance with out_ready high as soon as out_valid appears.
    task automatic run_op4(input string tag, input logic [63:0] a, input logic [63:0] b, input logic cin);
        int n;
        logic [MAXB:0] exp;
        @(negedge clk);
        if4.a = a; if4.b = b; if4.c_in = cin; if4.in_valid = 1'b1;
        sb[1].push_back(ref_sum(MAXB'(a), MAXB'(b), cin, 4));
        @(posedge clk);
        @(negedge clk);
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, (MAXB+1)'(n), (MAXB+1)'(4));
        if4.out_ready = 1'b1;
        exp = (sb[1].size() > 0) ? sb[1].pop_front() : '0;
        chk({tag, "_sum"}, obs_of(1), exp);
        @(posedge clk);
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, (MAXB+1)'(if4.in_ready), (MAXB+1)'(1'b1));
    endtask

    initial begin
        logic [MAXB:0]   exp;
        logic [MAXB-1:0] ra, rb;
        logic            rc;
        logic [2:0]      done;
        int              budget;
        bit              saw_valid;

        drive_all('0, '0, 1'b0, 1'b0);
        if2.out_ready = 1'b0; if4.out_ready = 1'b0; if7.out_ready = 1'b0;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  (MAXB+1)'(if4.in_ready),  (MAXB+1)'(1'b1));
        chk("rst_out_valid", (MAXB+1)'(if4.out_valid), '0);
        chk("rst_busy",      (MAXB+1)'(if4.busy),      '0);
        chk("rst_result",    obs_of(1),                '0);

        run_op4("ripple",    64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        run_op4("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        run_op4("all_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_op4("mixed",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);

        // Backpressure: hold DONE for 10 cycles with a stray in_valid present
        @(negedge clk);
        if4.a = 64'h0123_4567_89AB_CDEF; if4.b = 64'hFEDC_BA98_7654_3210; if4.c_in = 1'b1;
        if4.in_valid = 1'b1;
        sb[1].push_back(ref_sum(MAXB'(64'h0123_4567_89AB_CDEF), MAXB'(64'hFEDC_BA98_7654_3210), 1'b1, 4));
        @(posedge clk);
        @(negedge clk);
        if4.in_valid = 1'b0;
        budget = 0;
        while (!if4.out_valid && budget < 20) begin
            @(posedge clk);
            @(negedge clk);
            budget++;
        end
        chk("bp_latency", (MAXB+1)'(budget), (MAXB+1)'(4));
        exp = (sb[1].size() > 0) ? sb[1][0] : '0;
        if4.a = 64'h5555_5555_5555_5555; if4.c_in = 1'b0;
        if4.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", (MAXB+1)'(if4.out_valid), (MAXB+1)'(1'b1));
            chk("bp_in_ready",  (MAXB+1)'(if4.in_ready),  '0);
            chk("bp_result",    obs_of(1),                exp);
            @(posedge clk);
            @(negedge clk);
        end
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        chk("bp_release_result", obs_of(1), exp);
        if (sb[1].size() > 0) void'(sb[1].pop_front());
        @(posedge clk);
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk("bp_in_ready_after",  (MAXB+1)'(if4.in_ready),  (MAXB+1)'(1'b1));
        chk("bp_out_valid_after", (MAXB+1)'(if4.out_valid), '0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_stray_accept", (MAXB+1)'(if4.busy), '0);

        // Reset in cycle 2 of RUN
        @(negedge clk);
        if4.a = 64'h1234_5678_9ABC_DEF0; if4.b = 64'h1111_1111_1111_1111; if4.c_in = 1'b0;
        if4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.in_valid = 1'b0;
        chk("mr_busy_run", (MAXB+1)'(if4.busy), (MAXB+1)'(1'b1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mr_in_ready",  (MAXB+1)'(if4.in_ready),  (MAXB+1)'(1'b1));
        chk("mr_out_valid", (MAXB+1)'(if4.out_valid), '0);
        chk("mr_busy",      (MAXB+1)'(if4.busy),      '0);
        chk("mr_result",    obs_of(1),                '0);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (if4.out_valid) saw_valid = 1'b1;
        end
        chk("mr_no_valid", (MAXB+1)'(saw_valid), '0);
        run_op4("after_reset", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);

        // Random regression on all three widths in parallel, random out_ready stalls
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            ra = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
            rb = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
            if ((t % 16) == 0) ra = '1;
            rc = 1'($urandom_range(0, 1));
            drive_all(ra, rb, rc, 1'b1);
            for (int g = 0; g < 3; g++) sb[g].push_back(ref_sum(ra, rb, rc, words_of(g)));
            @(posedge clk);
            @(negedge clk);
            drive_all(ra, rb, rc, 1'b0);
            done = 3'b000;
            budget = 0;
            while (done != 3'b111 && budget < 200) begin
                for (int g = 0; g < 3; g++) begin
                    if (!done[g]) begin
                        set_ordy(g, ($urandom_range(0, 3) != 0));
                        if (ovalid_of(g) && ((g == 0) ? if2.out_ready : (g == 1) ? if4.out_ready : if7.out_ready)) begin
                            exp = (sb[g].size() > 0) ? sb[g].pop_front() : '0;
                            chk($sformatf("rnd_w%0d", words_of(g)), obs_of(g), exp);
                            done[g] = 1'b1;
                        end
                    end
                end
                @(posedge clk);
                @(negedge clk);
                for (int g = 0; g < 3; g++) set_ordy(g, 1'b0);
                budget++;
            end
            chk("rnd_done", (MAXB+1)'(done), (MAXB+1)'(3'b111));
            if (done != 3'b111) break;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rca_mp_add_seq.md
# rca_mp_add_seq

Multi-precision add sequencer. It adds two WORDS×16-bit operands by time-sharing a single 16-bit ripple-carry adder, one 16-bit word per cycle, least significant word first, with the carry registered between words. It sits between a requester using a valid/ready handshake and the shared 16-bit adder datapath, and owns that adder's operand and carry-in selection.

## Interface
Parameters:
- WORDS, default 4: number of 16-bit words per operand. Legal range 2..16.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: requester presents an operation.
- in_ready, output, 1: sequencer can accept an operation.
- a, input, 16*WORDS: operand A; sampled only on accept.
- b, input, 16*WORDS: operand B; sampled only on accept.
- c_in, input, 1: initial carry-in; sampled only on accept.
- out_valid, output, 1: result is available.
- out_ready, input, 1: consumer takes the result.
- s, output, 16*WORDS: sum, which is the low bits of a + b + c_in.
- c_out, output, 1: final carry, which is bit 16*WORDS of a + b + c_in.
- busy, output, 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b into operand registers, set carry register to c_in, set word index idx to 0, go to RUN.
- **RUN** (in_ready = 0, busy = 1)
  - The adder receives a_reg[idx], b_reg[idx] and the carry register.
  - Each cycle: write the adder sum into s[16*idx +: 16], load the adder carry-out into the carry register, increment idx.
  - When idx == WORDS-1, the last word is written and the carry-out is also loaded into c_out. Go to DONE.
- **DONE**
  - out_valid = 1; s and c_out are held stable.
  - On out_ready: go to IDLE.
  - No new operation is accepted in DONE, so there is no same-cycle re-accept.
- s and c_out keep their last values in IDLE. They are only overwritten word by word during the next RUN.
- in_valid is ignored outside IDLE. a, b and c_in may change freely after the accept edge.
- Arithmetic is modulo 2^(16*WORDS). The carry chain spans all words exactly as a full-width adder would. No overflow or signed interpretation.
- idx width is $clog2(WORDS). idx never exceeds WORDS-1.

## Timing
- **Reset values:** state = IDLE, in_ready = 1, out_valid = 0, busy = 0, s = 0, c_out = 0, idx = 0, carry = 0.
- **Reset mid-operation:** rst in RUN or DONE aborts the operation. All registers take their reset values on that edge. The pending result is discarded.
- **Latency:** with the accept edge at cycle 0, the RUN cycles are 1..WORDS, and out_valid rises on the edge ending cycle WORDS. The result is visible in cycle WORDS+1 (cycle 5 for WORDS=4).
- **Throughput:**
  - With out_ready held high, one operation completes every WORDS+2 cycles: accept, WORDS RUN cycles, one DONE cycle.
  - Back-to-back accepts are separated by exactly WORDS+2 cycles.
- **Backpressure:** DONE holds indefinitely while out_ready = 0. out_valid must not drop, and s and c_out must not change.
- **Critical path:** one 16-bit ripple chain plus the operand mux. It must not be chained across words within a cycle.

## Structure
- **Shared package rca_pkg:**
  - WORD_W = 16.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t.
- **Sub-module:** one instance of the team's existing 16-bit ripple-carry adder, which is the only arithmetic in the block. The rest is the FSM, operand and result registers, the idx counter and the word muxes.
- **Formal wrapper:** a companion formal wrapper asserts {c_out, s} == a_lat + b_lat + c_in_lat whenever out_valid, using latched copies taken on accept. It covers out_valid with c_out = 1 and s all ones.

## Test plan
- **Reset check:** assert rst for 2 cycles, then release. Require in_ready = 1, out_valid = 0, s = 0, c_out = 0.
- **Full carry ripple (WORDS=4):** a = 0x0000_0000_0000_FFFF, b = 0x1, c_in = 0. Require out_valid in cycle 5, s = 0x0000_0000_0001_0000, c_out = 0.
- **Carry through every word:** a = 0xFFFF_FFFF_FFFF_FFFF, b = 0, c_in = 1. Require s = 0, c_out = 1. Then a = 0xFFFF_FFFF_FFFF_FFFF, b = 0xFFFF_FFFF_FFFF_FFFF, c_in = 1. Require s = 0xFFFF_FFFF_FFFF_FFFF, c_out = 1.
- **Backpressure:** hold out_ready = 0 for 10 cycles after out_valid. Require out_valid, s and c_out stable, and in_ready = 0 throughout. Assert in_valid during DONE and require it to be ignored. On out_ready = 1, require in_ready = 1 on the next cycle.
- **Reset mid-RUN:** accept a = 0x1234_5678_9ABC_DEF0, b = 0x1111_1111_1111_1111. Pulse rst in cycle 2. Require the IDLE reset state on the next cycle, out_valid never asserted for that operation, and a following operation to complete correctly.
- **Random regression:** 1000 random a, b, c_in with random out_ready stalls, run at WORDS = 2, 4 and 7. Compare {c_out, s} against a 16*WORDS+1-bit reference sum.
